// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues one imem request per PC value, drives PC advance/hold,
// and feeds the IF/ID register while absorbing imem latency, ID stalls and branch flushes.
module if_fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [2:0]  pc_write_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        redir_done_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        ADV   = 3'd2,
        HOLD  = 3'd3,
        DROP  = 3'd4,
        REDIR = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [31:0] addr_q_r;
    logic        hold_v_r;
    logic [31:0] hold_pc_r;
    logic [31:0] hold_instr_r;

    logic [31:0] ifid_pc_r;
    logic [31:0] ifid_pc4_r;
    logic [31:0] ifid_instr_r;
    logic        ifid_valid_r;

    logic [2:0]  pc_write_r;
    logic        redir_done_r;
    logic        req_r;

    logic [2:0]  pc_write_nxt_s;
    logic        redir_done_nxt_s;
    logic        req_nxt_s;

    logic        load_s;
    logic        to_hold_s;
    logic        release_s;
    logic        new_word_s;
    logic [31:0] word_s;
    logic [31:0] word_pc_s;

    // State register plus the control outputs, registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= BOOT;
            pc_write_r   <= 3'b000;
            redir_done_r <= 1'b0;
            req_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_write_r   <= pc_write_nxt_s;
            redir_done_r <= redir_done_nxt_s;
            req_r        <= req_nxt_s;
        end
    end

    // Next-state logic and per-cycle datapath decisions (load, buffer, release)
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        to_hold_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            BOOT: begin
                state_nxt_s = FETCH;
            end
            FETCH: begin
                if (imem_ack_i) begin
                    if (flush_i) begin
                        state_nxt_s = REDIR;
                    end else begin
                        state_nxt_s = ADV;
                        if (!stall_i) begin
                            load_s = 1'b1;
                        end else begin
                            to_hold_s = 1'b1;
                        end
                    end
                end else if (flush_i) begin
                    state_nxt_s = DROP;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            ADV: begin
                if (flush_i) begin
                    state_nxt_s = REDIR;
                end else if (hold_v_r && !stall_i) begin
                    release_s   = 1'b1;
                    state_nxt_s = FETCH;
                end else if (hold_v_r) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_nxt_s = REDIR;
                end else if (!stall_i) begin
                    release_s   = 1'b1;
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            DROP: begin
                // a flush is already pending here, so only the ack matters
                if (imem_ack_i) begin
                    state_nxt_s = REDIR;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            REDIR: begin
                if (flush_i) begin
                    state_nxt_s = REDIR;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            default: begin
                state_nxt_s = BOOT;
            end
        endcase
    end

    // Control outputs decoded from the upcoming state
    always_comb begin
        pc_write_nxt_s   = 3'b000;
        redir_done_nxt_s = 1'b0;
        req_nxt_s        = 1'b0;
        case (state_nxt_s)
            FETCH:   req_nxt_s = 1'b1;
            DROP:    req_nxt_s = 1'b1;
            ADV:     pc_write_nxt_s = 3'b111;
            REDIR: begin
                pc_write_nxt_s   = 3'b111;
                redir_done_nxt_s = 1'b1;
            end
            default: begin
                pc_write_nxt_s   = 3'b000;
                redir_done_nxt_s = 1'b0;
                req_nxt_s        = 1'b0;
            end
        endcase
    end

    assign new_word_s = load_s | release_s;
    assign word_s     = release_s ? hold_instr_r : imem_rdata_i;
    assign word_pc_s  = release_s ? hold_pc_r : pc_in;

    // Request address latch and the one-deep hold buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q_r     <= 32'h0000_0000;
            hold_v_r     <= 1'b0;
            hold_pc_r    <= 32'h0000_0000;
            hold_instr_r <= NOP_INSTR;
        end else begin
            if (state_r == FETCH) begin
                addr_q_r <= pc_in;
            end
            if (flush_i) begin
                hold_v_r <= 1'b0;
            end else if (to_hold_s) begin
                hold_v_r     <= 1'b1;
                hold_pc_r    <= pc_in;
                hold_instr_r <= imem_rdata_i;
            end else if (release_s) begin
                hold_v_r <= 1'b0;
            end
        end
    end

    // IF/ID register: flush beats stall beats new word; otherwise a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
            ifid_pc_r    <= 32'h0000_0000;
            ifid_pc4_r   <= 32'h0000_0004;
        end else if (flush_i) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
        end else if (stall_i) begin
            ifid_valid_r <= ifid_valid_r;
        end else if (new_word_s) begin
            ifid_valid_r <= 1'b1;
            ifid_instr_r <= word_s;
            ifid_pc_r    <= word_pc_s;
            ifid_pc4_r   <= word_pc_s + 32'd4;
        end else begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
        end
    end

    assign pc_write_o   = pc_write_r;
    assign redir_done_o = redir_done_r;
    assign imem_req_o   = req_r;
    assign imem_addr_o  = (state_r == FETCH) ? pc_in : addr_q_r;
    assign ifid_pc_o    = ifid_pc_r;
    assign ifid_pc4_o   = ifid_pc4_r;
    assign ifid_instr_o = ifid_instr_r;
    assign ifid_valid_o = ifid_valid_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small ProgramCounter model and a hand-driven imem.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [2:0]  pc_write_o;
    logic        stall_i;
    logic        flush_i;
    logic        redir_done_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;

    logic [31:0] pc_r;
    logic        pend_r;
    logic [31:0] tgt;
    int          n_cmp;
    int          n_err;

    if_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .pc_write_o   (pc_write_o),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .redir_done_o (redir_done_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_instr_o (ifid_instr_o),
        .ifid_valid_o (ifid_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pc_in = pc_r;

    // ProgramCounter model: updates on the falling edge, loads the branch target when redirecting
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            pc_r   <= 32'h0000_3000;
            pend_r <= 1'b0;
        end else begin
            if (pc_write_o == 3'b111) begin
                if (pend_r || flush_i) pc_r <= tgt;
                else                   pc_r <= pc_r + 32'd4;
            end
            if (redir_done_o)  pend_r <= 1'b0;
            else if (flush_i)  pend_r <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // one cycle: drive inputs after the falling edge, sample just after the rising edge
    task automatic cyc(input logic ack, input logic stall, input logic flush);
        @(negedge clk);
        #1;
        imem_ack_i   = ack;
        imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;
        stall_i      = stall;
        flush_i      = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ifid(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic [31:0] instr);
        chk({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, v});
        chk({tag, ".pc"},    ifid_pc_o,    pc);
        chk({tag, ".pc4"},   ifid_pc4_o,   pc4);
        chk({tag, ".instr"}, ifid_instr_o, instr);
    endtask

    task automatic exp_ctl(input string tag, input logic req, input logic [31:0] addr,
                           input logic [2:0] pcw, input logic rd);
        chk({tag, ".req"},   {31'd0, imem_req_o},   {31'd0, req});
        chk({tag, ".pcw"},   {29'd0, pc_write_o},   {29'd0, pcw});
        chk({tag, ".redir"}, {31'd0, redir_done_o}, {31'd0, rd});
        if (req) chk({tag, ".addr"}, imem_addr_o, addr);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b0;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0000_0000;
        tgt          = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        exp_ifid("rst", 1'b0, 32'h0, 32'h4, 32'h0);
        exp_ctl("rst", 1'b0, 32'h0, 3'b000, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // T1: zero-latency ack, one instruction per two cycles
        cyc(1'b0, 1'b0, 1'b0);
        exp_ifid("t1a", 1'b0, 32'h0, 32'h4, 32'h0);
        exp_ctl("t1a", 1'b1, 32'h0000_3000, 3'b000, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        exp_ifid("t1b", 1'b1, 32'h0000_3000, 32'h0000_3004, 32'hA5A5_3000);
        exp_ctl("t1b", 1'b0, 32'h0, 3'b111, 1'b0);

        // T3: stall across the ack at 0x3004
        cyc(1'b0, 1'b1, 1'b0);
        exp_ifid("t3a", 1'b1, 32'h0000_3000, 32'h0000_3004, 32'hA5A5_3000);
        exp_ctl("t3a", 1'b1, 32'h0000_3004, 3'b000, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        exp_ifid("t3b", 1'b1, 32'h0000_3000, 32'h0000_3004, 32'hA5A5_3000);
        exp_ctl("t3b", 1'b0, 32'h0, 3'b111, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        exp_ifid("t3c", 1'b1, 32'h0000_3000, 32'h0000_3004, 32'hA5A5_3000);
        exp_ctl("t3c", 1'b0, 32'h0, 3'b000, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        exp_ifid("t3d", 1'b1, 32'h0000_3004, 32'h0000_3008, 32'hA5A5_3004);
        exp_ctl("t3d", 1'b1, 32'h0000_3008, 3'b000, 1'b0);

        // T4: flush with request outstanding, ack two cycles later
        tgt = 32'h0000_3100;
        cyc(1'b0, 1'b0, 1'b1);
        exp_ifid("t4a", 1'b0, 32'h0000_3004, 32'h0000_3008, 32'h0);
        exp_ctl("t4a", 1'b1, 32'h0000_3008, 3'b000, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        exp_ctl("t4b", 1'b1, 32'h0000_3008, 3'b000, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        exp_ifid("t4c", 1'b0, 32'h0000_3004, 32'h0000_3008, 32'h0);
        exp_ctl("t4c", 1'b0, 32'h0, 3'b111, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        exp_ifid("t4d", 1'b0, 32'h0000_3004, 32'h0000_3008, 32'h0);
        exp_ctl("t4d", 1'b1, 32'h0000_3100, 3'b000, 1'b0);

        // T5: flush, stall and ack in the same cycle
        cyc(1'b1, 1'b0, 1'b0);
        exp_ifid("t5a", 1'b1, 32'h0000_3100, 32'h0000_3104, 32'hA5A5_3100);
        cyc(1'b0, 1'b1, 1'b0);
        exp_ctl("t5b", 1'b1, 32'h0000_3104, 3'b000, 1'b0);
        tgt = 32'h0000_3200;
        cyc(1'b1, 1'b1, 1'b1);
        exp_ifid("t5c", 1'b0, 32'h0000_3100, 32'h0000_3104, 32'h0);
        exp_ctl("t5c", 1'b0, 32'h0, 3'b111, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        exp_ifid("t5d", 1'b0, 32'h0000_3100, 32'h0000_3104, 32'h0);
        exp_ctl("t5d", 1'b1, 32'h0000_3200, 3'b000, 1'b0);

        // T6: reset asserted while in DROP
        tgt = 32'h0000_3300;
        cyc(1'b0, 1'b0, 1'b1);
        exp_ctl("t6a", 1'b1, 32'h0000_3200, 3'b000, 1'b0);
        reset   = 1'b0;
        flush_i = 1'b0;
        #1;
        exp_ifid("t6rst", 1'b0, 32'h0, 32'h4, 32'h0);
        exp_ctl("t6rst", 1'b0, 32'h0, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset      = 1'b1;
        imem_ack_i = 1'b1;

        // T2: stale ack during BOOT ignored, then 3-cycle ack latency
        cyc(1'b0, 1'b0, 1'b0);
        exp_ifid("t2a", 1'b0, 32'h0, 32'h4, 32'h0);
        exp_ctl("t2a", 1'b1, 32'h0000_3000, 3'b000, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        exp_ctl("t2b", 1'b1, 32'h0000_3000, 3'b000, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        exp_ctl("t2c", 1'b1, 32'h0000_3000, 3'b000, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        exp_ifid("t2d", 1'b1, 32'h0000_3000, 32'h0000_3004, 32'hA5A5_3000);
        exp_ctl("t2d", 1'b0, 32'h0, 3'b111, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        exp_ifid("t2e", 1'b0, 32'h0000_3000, 32'h0000_3004, 32'h0);
        exp_ctl("t2e", 1'b1, 32'h0000_3004, 3'b000, 1'b0);

        // pc4 wrap at the top of the address space
        tgt = 32'hFFFF_FFFC;
        cyc(1'b0, 1'b0, 1'b1);
        exp_ctl("wra", 1'b1, 32'h0000_3004, 3'b000, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        exp_ctl("wrb", 1'b0, 32'h0, 3'b111, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        exp_ctl("wrc", 1'b1, 32'hFFFF_FFFC, 3'b000, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        exp_ifid("wrd", 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h5A5A_FFFC);
        cyc(1'b0, 1'b0, 1'b0);
        exp_ctl("wre", 1'b1, 32'h0000_0000, 3'b000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
